// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_LSL = 3'd5,
    ALU_LSR = 3'd6,
    ALU_ASR = 3'd7
  } alu_op_e;

  // Bit positions inside a {N,Z,C,V} nibble.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] nzcv_t;

  // Width-independent part of the S1 stage word. The operand fields depend on
  // WIDTH, so the full s1_t is declared inside alu_pipe around this struct.
  typedef struct packed {
    alu_op_e op;
    logic    set_flags;
  } s1_ctrl_t;

  function automatic nzcv_t pack_nzcv(input logic n, input logic z,
                                      input logic c, input logic v);
    nzcv_t f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: {a, b, op} -> {result, NZCV}.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] result_o,
  output nzcv_t            nzcv_o
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]      shamt;
  logic [WIDTH:0]      sum;    // extra MSB holds the carry out
  logic [WIDTH:0]      lsl_w;  // extra MSB catches the last bit shifted out
  logic [WIDTH:0]      lsr_w;  // extra LSB catches the last bit shifted out
  logic signed [WIDTH:0] asr_w;
  logic                c_flag;
  logic                v_flag;

  assign shamt = b_i[SHW-1:0];

  // Select the operation result and derive carry/overflow for it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a value unassigned and infer a latch.
    result_o = '0;
    c_flag   = 1'b0;
    v_flag   = 1'b0;
    sum      = '0;
    lsl_w    = '0;
    lsr_w    = '0;
    asr_w    = '0;
    unique case (op_i)
      ALU_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[WIDTH-1:0];
        c_flag   = sum[WIDTH];
        v_flag   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_SUB: begin
        // Carry out of a + ~b + 1 is 1 exactly when no borrow occurs.
        sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
        result_o = sum[WIDTH-1:0];
        c_flag   = sum[WIDTH];
        v_flag   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (result_o[WIDTH-1] != a_i[WIDTH-1]);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_LSL: begin
        lsl_w    = {1'b0, a_i} << shamt;
        result_o = lsl_w[WIDTH-1:0];
        c_flag   = lsl_w[WIDTH];
      end
      ALU_LSR: begin
        lsr_w    = {a_i, 1'b0} >> shamt;
        result_o = lsr_w[WIDTH:1];
        c_flag   = lsr_w[0];
      end
      ALU_ASR: begin
        asr_w    = $signed({a_i, 1'b0}) >>> shamt;
        result_o = asr_w[WIDTH:1];
        c_flag   = asr_w[0];
      end
    endcase
    nzcv_o = pack_nzcv(result_o[WIDTH-1], result_o == '0, c_flag, v_flag);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and an NZCV register
// that is written only when a flag-setting beat retires.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags,
  output logic [3:0]       flags_q
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    s1_ctrl_t         ctrl;
  } s1_t;

  s1_t              s1_q, s1_d;
  logic             s1_v_q, s1_v_d;
  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] result_q, result_d;
  nzcv_t            alu_flags_q, alu_flags_d;
  logic             s2_set_flags_q, s2_set_flags_d;
  nzcv_t            flags_d;

  logic             accept;
  logic             s2_load;
  logic             retire;
  logic [WIDTH-1:0] core_result;
  nzcv_t            core_nzcv;

  // A full pipe can still accept when the output beat is leaving this cycle.
  assign in_ready  = ~s1_v_q | ~s2_v_q | out_ready;
  assign accept    = in_valid & in_ready;
  assign s2_load   = s1_v_q & (~s2_v_q | out_ready);
  assign retire    = s2_v_q & out_ready;

  assign out_valid = s2_v_q;
  assign result    = result_q;
  assign alu_flags = alu_flags_q;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (s1_q.a),
    .b_i      (s1_q.b),
    .op_i     (s1_q.ctrl.op),
    .result_o (core_result),
    .nzcv_o   (core_nzcv)
  );

  // Next-state for both stages and the architectural flag register.
  always_comb begin
    s1_d           = s1_q;
    s1_v_d         = s1_v_q;
    s2_v_d         = s2_v_q;
    result_d       = result_q;
    alu_flags_d    = alu_flags_q;
    s2_set_flags_d = s2_set_flags_q;
    flags_d        = flags_q;

    if (accept) begin
      s1_d.a              = a;
      s1_d.b              = b;
      s1_d.ctrl.op        = alu_op_e'(op);
      s1_d.ctrl.set_flags = set_flags;
      s1_v_d              = 1'b1;
    end else if (s2_load) begin
      s1_v_d = 1'b0;
    end

    if (s2_load) begin
      s2_v_d         = 1'b1;
      result_d       = core_result;
      alu_flags_d    = core_nzcv;
      s2_set_flags_d = s1_q.ctrl.set_flags;
    end else if (retire) begin
      s2_v_d = 1'b0;
    end

    // Flags commit only for a beat the consumer actually takes.
    if (retire && s2_set_flags_q) begin
      flags_d = alu_flags_q;
    end
  end

  // Stage registers and flag register; reset discards any in-flight beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the data registers are reset as well because result and
      // alu_flags are visible on the ports and must read zero out of reset.
      s1_q           <= '0;
      s1_v_q         <= 1'b0;
      s2_v_q         <= 1'b0;
      result_q       <= '0;
      alu_flags_q    <= '0;
      s2_set_flags_q <= 1'b0;
      flags_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      s1_q           <= s1_d;
      s1_v_q         <= s1_v_d;
      s2_v_q         <= s2_v_d;
      result_q       <= result_d;
      alu_flags_q    <= alu_flags_d;
      s2_set_flags_q <= s2_set_flags_d;
      flags_q        <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: a queue-based reference model with a
// per-cycle compare process, directed corner cases and a randomized phase.
module tb_alu_pipe;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_LSL = 3'd5;
  localparam logic [2:0] OP_LSR = 3'd6;
  localparam logic [2:0] OP_ASR = 3'd7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic        set_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  alu_flags;
  logic [3:0]  flags_q;

  alu_pipe #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .set_flags (set_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .alu_flags (alu_flags),
    .flags_q   (flags_q)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference ALU written from the arithmetic definitions, using wide signed
  // and unsigned integers rather than carry-chain tricks.
  function automatic void ref_alu(input logic [31:0] av, input logic [31:0] bv,
                                  input logic [2:0] opv,
                                  output logic [31:0] r, output logic [3:0] f);
    longint sa, sb, exact;
    logic signed [31:0] sa32;
    logic c, v;
    int s;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    sa32 = av;
    s = int'(bv[4:0]);
    c = 1'b0;
    v = 1'b0;
    exact = 0;
    case (opv)
      3'd0: begin
        r = av + bv;
        c = ({32'h0, av} + {32'h0, bv}) > 64'hFFFF_FFFF;
        exact = sa + sb;
        v = exact != longint'($signed(r));
      end
      3'd1: begin
        r = av - bv;
        c = av >= bv;
        exact = sa - sb;
        v = exact != longint'($signed(r));
      end
      3'd2: r = av & bv;
      3'd3: r = av | bv;
      3'd4: r = av ^ bv;
      3'd5: begin r = av << s;    c = (s == 0) ? 1'b0 : av[32 - s]; end
      3'd6: begin r = av >> s;    c = (s == 0) ? 1'b0 : av[s - 1];  end
      default: begin r = sa32 >>> s; c = (s == 0) ? 1'b0 : av[s - 1]; end
    endcase
    f = {r[31], r == 32'h0, c, v};
  endfunction

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic        sf;
    int          acc;
  } exp_t;

  exp_t       q[$];
  logic [3:0] model_flags;
  int         cyc;
  int         n_retired = 0;

  // Compare process: one pass per cycle at the falling edge, when all DUT
  // outputs and bench inputs are settled.
  initial begin
    exp_t        e;
    logic        hold_prev;
    logic [31:0] prev_r;
    logic [3:0]  prev_f;
    logic [31:0] mr;
    logic [3:0]  mf;
    hold_prev = 1'b0;
    prev_r = '0;
    prev_f = '0;
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n) begin
        q.delete();
        model_flags = 4'h0;
        cyc = 0;
        hold_prev = 1'b0;
      end else begin
        cyc++;
        check("in_ready", in_ready, (q.size() < 2) || out_ready);
        check("out_valid", out_valid, (q.size() != 0) && (cyc >= q[0].acc + 2));
        if (hold_prev && out_valid) begin
          check("hold_result", result, prev_r);
          check("hold_flags", alu_flags, prev_f);
        end
        check("flags_q", flags_q, model_flags);
        if (out_valid && out_ready && q.size() != 0) begin
          e = q.pop_front();
          check("result", result, e.r);
          check("alu_flags", alu_flags, e.f);
          if (e.sf) model_flags = e.f;
          n_retired++;
        end
        if (in_valid && in_ready) begin
          ref_alu(a, b, op, mr, mf);
          e.r = mr;
          e.f = mf;
          e.sf = set_flags;
          e.acc = cyc;
          q.push_back(e);
        end
        hold_prev = out_valid && !out_ready;
        prev_r = result;
        prev_f = alu_flags;
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'h1;
      default: return $urandom();
    endcase
  endfunction

  task automatic drive_random();
    a = pick();
    b = pick();
    op = 3'($urandom_range(0, 7));
    set_flags = 1'($urandom_range(0, 1));
  endtask

  // Called half a tick after a rising edge; returns the same way after the
  // edge on which the beat was accepted.
  task automatic send(input logic [31:0] av, input logic [31:0] bv,
                      input logic [2:0] opv, input logic sf);
    bit ok = 0;
    a = av; b = bv; op = opv; set_flags = sf; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    check("send_accept", ok, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_beat(input string name, input logic [31:0] r, input logic [3:0] f);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin seen = 1; break; end
    end
    check({name, "_seen"}, seen, 1);
    if (seen) begin
      check({name, "_result"}, result, r);
      check({name, "_flags"}, alu_flags, f);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] mr;
    logic [3:0]  mf;
    int          accepts;
    int          n0;
    bit          acc;

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0; set_flags = 1'b0;

    // Pin the reference model to hand-computed values.
    ref_alu(32'h7FFF_FFFF, 32'h1, OP_ADD, mr, mf);
    check("model_add_r", mr, 32'h8000_0000); check("model_add_f", mf, 4'b1001);
    ref_alu(32'h5, 32'h5, OP_SUB, mr, mf);
    check("model_sub0_f", mf, 4'b0110);
    ref_alu(32'h3, 32'h5, OP_SUB, mr, mf);
    check("model_subn_r", mr, 32'hFFFF_FFFE); check("model_subn_f", mf, 4'b1000);
    ref_alu(32'h8000_0001, 32'h1, OP_LSL, mr, mf);
    check("model_lsl_r", mr, 32'h2); check("model_lsl_f", mf, 4'b0010);
    ref_alu(32'h8000_0000, 32'd31, OP_ASR, mr, mf);
    check("model_asr_r", mr, 32'hFFFF_FFFF); check("model_asr_f", mf, 4'b1000);

    // Reset state.
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_alu_flags", alu_flags, 0);
    check("rst_flags_q", flags_q, 0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Signed overflow on ADD, with exact two-cycle latency from the accept cycle.
    send(32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b0);
    @(negedge clk); check("lat_cycle1", out_valid, 0);
    @(negedge clk); check("lat_cycle2", out_valid, 1);
    check("add_ovf_result", result, 32'h8000_0000);
    check("add_ovf_flags", alu_flags, 4'b1001);
    @(posedge clk); #1;

    send(32'h5, 32'h5, OP_SUB, 1'b1);
    expect_beat("sub_zero", 32'h0, 4'b0110);
    check("sub_zero_flags_q", flags_q, 4'b0110);
    send(32'h3, 32'h5, OP_SUB, 1'b0);
    expect_beat("sub_neg", 32'hFFFF_FFFE, 4'b1000);
    send(32'h8000_0001, 32'h1, OP_LSL, 1'b0);
    expect_beat("lsl1", 32'h2, 4'b0010);
    send(32'h8000_0000, 32'd31, OP_ASR, 1'b0);
    expect_beat("asr31", 32'hFFFF_FFFF, 4'b1000);
    send(32'h1234_5678, 32'h0, OP_LSR, 1'b0);
    expect_beat("lsr0", 32'h1234_5678, 4'b0000);

    // A non-flag-setting beat must not disturb the committed flags.
    send(32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b1);
    expect_beat("add_sf", 32'h8000_0000, 4'b1001);
    check("add_sf_flags_q", flags_q, 4'b1001);
    send(32'h0, 32'h0, OP_AND, 1'b0);
    expect_beat("and_nosf", 32'h0, 4'b0100);
    @(negedge clk);
    check("and_nosf_flags_q", flags_q, 4'b1001);
    @(posedge clk); #1;

    // Back-pressure: consumer stalls for five cycles while four beats are offered.
    out_ready = 1'b0;
    accepts = 0;
    n0 = n_retired;
    drive_random(); in_valid = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k >= 2 && k < 5) check("bp_in_ready_low", in_ready, 0);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) accepts++;
      if (acc && accepts < 4) drive_random();
      else if (acc) in_valid = 1'b0;
      out_ready = (k >= 4);
    end
    check("bp_accepts", accepts, 4);
    check("bp_retired", n_retired - n0, 4);

    // Back-to-back: one accept every cycle while results drain every cycle.
    n0 = n_retired;
    drive_random(); in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b2b_in_ready", in_ready, 1);
      @(posedge clk); #1;
      drive_random();
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_retired", n_retired - n0, 8);

    // Asynchronous reset pulse in the middle of a stream.
    send(32'h7FFF_FFFF, 32'h1, OP_ADD, 1'b1);
    expect_beat("pre_rst", 32'h8000_0000, 4'b1001);
    drive_random(); in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    check("arst_out_valid", out_valid, 0);
    check("arst_flags_q", flags_q, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk); check("arst_lat_cycle1", out_valid, 0);
    @(negedge clk); check("arst_lat_cycle2", out_valid, 1);
    @(posedge clk); #1;

    // Randomized traffic with random consumer stalls.
    for (int k = 0; k < 1500; k++) begin
      drive_random();
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
    check("drain_out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
